// File: rtl/lfsr5_checker.sv
// ---------------------------------------------------------------------------
// lfsr5_checker
//
// Purpose:
//   Consumes the q stream of the 5-bit Galois LFSR generator and checks it.
//   The checker hunts for a nonzero seed and then verifies LOCK_COUNT
//   consecutive predictions before it declares lock. While locked it runs a
//   flywheel, so the prediction advances whatever the input is. This makes a
//   single corrupted sample produce exactly one error. UNLOCK_COUNT
//   consecutive mismatches drop the checker back to hunting.
//
// Parameters:
//   LOCK_COUNT   consecutive good predictions in VERIFY needed to lock (1..15)
//   UNLOCK_COUNT consecutive misses in LOCKED that force HUNT (1..15)
//   ERR_W        width of the saturating error counter
//
// Ports:
//   clk        in   clock, posedge
//   reset      in   synchronous, active-high reset
//   in_valid   in   qualifies in_data; nothing advances while low
//   in_data    in   5-bit LFSR sample
//   locked     out  registered, high while in LOCKED
//   err_pulse  out  registered one-cycle pulse per mismatched sample in LOCKED
//   err_count  out  saturating count of mismatches seen while LOCKED
//   zero_seen  out  sticky flag, a valid all-zero sample was received
//
// Optional feature (macro LFSR5_CHK_WRAP_EN):
//   wrap_pulse out  registered pulse after each matching 5'h01 while LOCKED
//   wrap_count out  8-bit count of wrap pulses, wraps modulo 256
// ---------------------------------------------------------------------------
module lfsr5_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_seen
`ifdef LFSR5_CHK_WRAP_EN
    ,
    output logic             wrap_pulse,
    output logic [7:0]       wrap_count
`endif
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    state_t           state_q, state_d;
    logic [4:0]       exp_q, exp_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             zero_q, zero_d;
`ifdef LFSR5_CHK_WRAP_EN
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
`endif

    // Galois update of the generator: the feedback tap folds x[0] into bit 2.
    function automatic logic [4:0] pred(input logic [4:0] x);
        return {x[0], x[4], x[3] ^ x[0], x[2], x[1]};
    endfunction

    // The counter holds at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
        return (&x) ? x : x + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        zero_d      = zero_q;
        err_pulse_d = 1'b0;
`ifdef LFSR5_CHK_WRAP_EN
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
`endif
        if (in_valid) begin
            if (in_data == 5'h00) begin
                zero_d = 1'b1;
            end
            unique case (state_q)
                S_HUNT: begin
                    if (in_data != 5'h00) begin
                        exp_d   = pred(in_data);
                        match_d = 4'd0;
                        state_d = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    // exp_q is never zero, so a zero sample always misses.
                    if (in_data == exp_q) begin
                        match_d = match_q + 4'd1;
                        exp_d   = pred(in_data);
                        if (match_q + 4'd1 == LOCK_N) begin
                            miss_d  = 4'd0;
                            state_d = S_LOCKED;
                        end
                    end else if (in_data == 5'h00) begin
                        state_d = S_HUNT;
                    end else begin
                        exp_d   = pred(in_data);
                        match_d = 4'd0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: the prediction never re-seeds from input here.
                    exp_d = pred(exp_q);
                    if (in_data == exp_q) begin
                        miss_d = 4'd0;
`ifdef LFSR5_CHK_WRAP_EN
                        if (in_data == 5'h01) begin
                            wrap_pulse_d = 1'b1;
                            wrap_cnt_d   = wrap_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        miss_d      = miss_q + 4'd1;
                        if (miss_q + 4'd1 == UNLOCK_N) begin
                            state_d = S_HUNT;
                        end
                    end
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase
        end
        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HUNT;
            exp_q       <= 5'h00;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            zero_q      <= 1'b0;
`ifdef LFSR5_CHK_WRAP_EN
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            zero_q      <= zero_d;
`ifdef LFSR5_CHK_WRAP_EN
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign zero_seen = zero_q;
`ifdef LFSR5_CHK_WRAP_EN
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr5_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr5_checker
//
// Self-checking bench for lfsr5_checker. Two instances share one stimulus
// stream: the default ERR_W=16 and an ERR_W=4 copy used for saturation.
// The driver pushes expected outputs to a queue on the falling edge.
// The monitor pops them and compares them 1 time unit after the next rising
// edge. The wrap outputs are connected when LFSR5_CHK_WRAP_EN is defined.
// ---------------------------------------------------------------------------
module tb_lfsr5_checker;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_data;
    logic        locked,  locked4;
    logic        err_pulse, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
    logic        zero_seen, zero_seen4;
`ifdef LFSR5_CHK_WRAP_EN
    logic        wrap_pulse, wrap_pulse4;
    logic [7:0]  wrap_count, wrap_count4;
`endif

    lfsr5_checker #(.LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .zero_seen(zero_seen)
`ifdef LFSR5_CHK_WRAP_EN
        , .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
`endif
    );

    lfsr5_checker #(.LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4),
        .zero_seen(zero_seen4)
`ifdef LFSR5_CHK_WRAP_EN
        , .wrap_pulse(wrap_pulse4), .wrap_count(wrap_count4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic lk;
        logic ep;
        int   ec;
        int   ec4;
        logic zs;
        logic wp;
        int   wc;
        int   id;
    } exp_t;

    typedef struct {
        logic       v;
        logic [4:0] d;
        logic       lk;
        logic       ep;
        int         ec;
        logic       zs;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[10];

    int n_cmp  = 0;
    int n_fail = 0;
    int drv_id = 0;

    // Reference model state
    int         m_state;   // 0 hunt, 1 verify, 2 locked
    logic [4:0] m_exp;
    int         m_match, m_miss, m_errs, m_wrap;
    logic       m_pulse, m_zero, m_wpulse;
    logic [4:0] gen;

    function automatic logic [4:0] lfsr_next(input logic [4:0] x);
        return {x[0], x[4], x[3] ^ x[0], x[2], x[1]};
    endfunction

    task automatic chk(input string name, input int id, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, want %0d", name, id, act, req);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [4:0] d);
        if (r) begin
            m_state = 0; m_exp = 5'h00; m_match = 0; m_miss = 0; m_errs = 0;
            m_wrap = 0; m_pulse = 1'b0; m_zero = 1'b0; m_wpulse = 1'b0;
        end else begin
            m_pulse  = 1'b0;
            m_wpulse = 1'b0;
            if (v) begin
                if (d == 5'h00) m_zero = 1'b1;
                if (m_state == 0) begin
                    if (d != 5'h00) begin
                        m_exp = lfsr_next(d); m_match = 0; m_state = 1;
                    end
                end else if (m_state == 1) begin
                    if (d == m_exp) begin
                        m_match++;
                        m_exp = lfsr_next(d);
                        if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
                    end else if (d == 5'h00) begin
                        m_state = 0;
                    end else begin
                        m_exp = lfsr_next(d); m_match = 0;
                    end
                end else begin
                    if (d == m_exp) begin
                        m_miss = 0;
                        if (d == 5'h01) begin
                            m_wpulse = 1'b1;
                            m_wrap = (m_wrap + 1) % 256;
                        end
                    end else begin
                        m_pulse = 1'b1;
                        m_errs++;
                        m_miss++;
                        if (m_miss == UNLOCK) m_state = 0;
                    end
                    m_exp = lfsr_next(m_exp);
                end
            end
        end
    endtask

    function automatic exp_t model_exp(input int id);
        exp_t e;
        e.lk  = (m_state == 2);
        e.ep  = m_pulse;
        e.ec  = (m_errs > 65535) ? 65535 : m_errs;
        e.ec4 = (m_errs > 15) ? 15 : m_errs;
        e.zs  = m_zero;
        e.wp  = m_wpulse;
        e.wc  = m_wrap;
        e.id  = id;
        return e;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [4:0] d);
        @(negedge clk);
        reset    = r;
        in_valid = v;
        in_data  = d;
        model_step(r, v, d);
        sbq.push_back(model_exp(drv_id));
        drv_id++;
    endtask

    task automatic good();
        drive(1'b0, 1'b1, gen);
        gen = lfsr_next(gen);
    endtask

    task automatic bad();
        drive(1'b0, 1'b1, gen ^ 5'h04);
        gen = lfsr_next(gen);
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("locked",     mon_e.id, int'(locked),     int'(mon_e.lk));
            chk("err_pulse",  mon_e.id, int'(err_pulse),  int'(mon_e.ep));
            chk("err_count",  mon_e.id, int'(err_count),  mon_e.ec);
            chk("zero_seen",  mon_e.id, int'(zero_seen),  int'(mon_e.zs));
            chk("locked_w4",  mon_e.id, int'(locked4),    int'(mon_e.lk));
            chk("err_count4", mon_e.id, int'(err_count4), mon_e.ec4);
`ifdef LFSR5_CHK_WRAP_EN
            chk("wrap_pulse", mon_e.id, int'(wrap_pulse), int'(mon_e.wp));
            chk("wrap_count", mon_e.id, int'(wrap_count), mon_e.wc);
`endif
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 5'h00;
        model_step(1'b1, 1'b0, 5'h00);

        // Lock acquisition from 01, a gap carrying zero data, and one
        // corrupted sample (1C^04). Outputs are listed as seen after each edge.
        tbl[0] = '{1'b1, 5'h01, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b1, 5'h14, 1'b0, 1'b0, 0, 1'b0};
        tbl[2] = '{1'b1, 5'h0A, 1'b0, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b1, 5'h05, 1'b0, 1'b0, 0, 1'b0};
        tbl[4] = '{1'b1, 5'h16, 1'b1, 1'b0, 0, 1'b0};
        tbl[5] = '{1'b0, 5'h00, 1'b1, 1'b0, 0, 1'b0};
        tbl[6] = '{1'b1, 5'h0B, 1'b1, 1'b0, 0, 1'b0};
        tbl[7] = '{1'b1, 5'h11, 1'b1, 1'b0, 0, 1'b0};
        tbl[8] = '{1'b1, 5'h18, 1'b1, 1'b1, 1, 1'b0};
        tbl[9] = '{1'b1, 5'h0E, 1'b1, 1'b0, 1, 1'b0};

        drive(1'b1, 1'b0, 5'h00);
        drive(1'b1, 1'b1, 5'h00);

        for (int i = 0; i < 10; i++) begin
            exp_t e;
            @(negedge clk);
            reset    = 1'b0;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            model_step(1'b0, tbl[i].v, tbl[i].d);
            e     = model_exp(drv_id);
            e.lk  = tbl[i].lk;
            e.ep  = tbl[i].ep;
            e.ec  = tbl[i].ec;
            e.ec4 = tbl[i].ec;
            e.zs  = tbl[i].zs;
            sbq.push_back(e);
            drv_id++;
        end
        gen = lfsr_next(5'h0E);

        // Loss of lock after three misses, then re-lock on LOCK+1 good samples.
        repeat (3) bad();
        repeat (LOCK + 1) good();
        repeat (4) good();

        // Random valid gaps while locked. Data during a gap is junk.
        begin
            int sent = 0;
            for (int k = 0; k < 400 && sent < 62; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    good();
                    sent++;
                end else begin
                    drive(1'b0, 1'b0, 5'($urandom_range(0, 31)));
                end
            end
        end

        // Zero sample in VERIFY, then zero sample in LOCKED.
        repeat (3) bad();
        good();
        drive(1'b0, 1'b1, 5'h00);
        repeat (LOCK + 1) good();
        drive(1'b0, 1'b1, 5'h00);
        gen = lfsr_next(gen);
        repeat (3) good();

        // Repeated lock losses until the 4-bit counter saturates.
        for (int r = 0; r < 20 && m_errs < 20; r++) begin
            repeat (3) bad();
            repeat (LOCK + 1) good();
        end
        repeat (2) good();

        // Reset mid-lock, then re-lock and run two full periods.
        drive(1'b1, 1'b1, gen);
        gen = lfsr_next(gen);
        repeat (LOCK + 1) good();
        repeat (62) good();
        drive(1'b0, 1'b0, 5'h00);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", drv_id, sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
